extractor: RTL and testbench

- Testbench-side sink that receives anonymized (IP address, URL) records from the DUT output stream.
- Captures each record into an internal buffer, counts records, flags overflow.
- Exposes the captured buffer through a synchronous, address-indexed read port for post-run checking.
- It is the receive-side counterpart of the ROM-backed record source: records enter on a valid/ready stream and are read back by address.

---
 rtl/extractor_pkg.sv | 15 +
 rtl/extractor_if.sv | 25 ++
 rtl/extractor_capture_ram.sv | 30 +++
 rtl/extractor.sv | 76 +++++++
 tb/tb_extractor.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/extractor_pkg.sv
// Shared types and default widths for the record capture sink.
package extractor_pkg;

  localparam int DEF_IP_WIDTH   = 32;
  localparam int DEF_URL_WIDTH  = 512;
  localparam int DEF_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  typedef struct packed {
    logic [DEF_IP_WIDTH-1:0]  ip;
    logic [DEF_URL_WIDTH-1:0] url;
  } record_t;

endpackage

// File: rtl/extractor_if.sv
// Record stream in, address-indexed read port out.
interface extractor_if #(
  parameter int IP_WIDTH   = 32,
  parameter int URL_WIDTH  = 512,
  parameter int ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IP_WIDTH-1:0]   in_ip_addr_data;
  logic [URL_WIDTH-1:0]  in_url_data;
  logic                  in_last;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [IP_WIDTH-1:0]   rd_ip_addr_data;
  logic [URL_WIDTH-1:0]  rd_url_data;

  modport sink (
    input  in_valid, in_ip_addr_data, in_url_data, in_last, rd_address,
    output in_ready, rd_ip_addr_data, rd_url_data
  );

  modport source (
    output in_valid, in_ip_addr_data, in_url_data, in_last, rd_address,
    input  in_ready, rd_ip_addr_data, rd_url_data
  );
endinterface

// File: rtl/extractor_capture_ram.sv
// Simple dual-port record buffer: one write port, registered read with old-data
// on a same-cycle read/write collision.
module capture_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 544
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents deliberately survive reset so a partial run can still be inspected.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/extractor.sv
// Record capture sink: stores accepted records in order, counts them, and
// tracks records dropped once the buffer is full.
module extractor
  import extractor_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 4096,
  parameter int IP_WIDTH   = DEF_IP_WIDTH,
  parameter int URL_WIDTH  = DEF_URL_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  extractor_if.sink             io,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drops
);
  localparam int DW = IP_WIDTH + URL_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                 state_q;
  logic [ADDR_WIDTH:0]    count_q;
  logic                   ovf_q;
  logic [CNT_WIDTH-1:0]   drops_q;
  logic                   accept, full, we;
  logic [DW-1:0]          rd_data;

  // Ready is a pure function of state so a full buffer never stalls the source.
  assign io.in_ready = (state_q == CAPTURE);
  assign accept      = io.in_valid && io.in_ready;
  assign full        = (count_q == FULL);
  assign we          = accept && !start && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else if (start) begin
      // Start re-arms from any state; a beat in the same cycle is discarded.
      state_q <= CAPTURE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else if (accept) begin
      if (!full) begin
        count_q <= count_q + 1'b1;
      end else begin
        ovf_q <= 1'b1;
        if (drops_q != '1) drops_q <= drops_q + 1'b1;
      end
      if (io.in_last) state_q <= DONE;
    end
  end

  capture_ram #(.DEPTH(DEPTH), .AW(ADDR_WIDTH), .DW(DW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .waddr_i (count_q[ADDR_WIDTH-1:0]),
    .wdata_i ({io.in_ip_addr_data, io.in_url_data}),
    .raddr_i (io.rd_address),
    .rdata_o (rd_data)
  );

  assign io.rd_ip_addr_data = rd_data[DW-1 -: IP_WIDTH];
  assign io.rd_url_data     = rd_data[URL_WIDTH-1:0];
  assign count              = count_q;
  assign done               = (state_q == DONE);
  assign overflow           = ovf_q;
  assign drops              = drops_q;
endmodule

// File: tb/tb_extractor.sv
// Directed/random bench for extractor against an array-based buffer model.
module tb_extractor;
  import extractor_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 2;
  localparam int DMAX  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   count;
  logic          done, overflow;
  logic [CW-1:0] drops;

  extractor_if #(.IP_WIDTH(32), .URL_WIDTH(512), .ADDR_WIDTH(AW)) bus ();

  extractor #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .IP_WIDTH(32), .URL_WIDTH(512),
              .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .io(bus),
    .count(count), .done(done), .overflow(overflow), .drops(drops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: buffer slots (stale contents kept), record count, flags.
  record_t mem_m [DEPTH];
  bit      wr_m  [DEPTH];
  int      m_count = 0;
  int      m_drops = 0;
  bit      m_ovf = 0, m_cap = 0, m_done = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_url();
    logic [511:0] u;
    for (int i = 0; i < 16; i++) u[i*32 +: 32] = $urandom;
    return u;
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 512'(count), 512'(m_count));
    chk({tag, ".done"}, 512'(done), 512'(m_done));
    chk({tag, ".overflow"}, 512'(overflow), 512'(m_ovf));
    chk({tag, ".drops"}, 512'(drops), 512'(m_drops));
  endtask

  // One clock cycle: drive a beat (or idle), optional start, read address ra.
  task automatic step(input string tag, input bit v, input logic [31:0] ip,
                      input logic [511:0] url, input bit last, input bit st, input int ra);
    record_t old;
    bit      oldv;
    logic [AW-1:0] a;
    a = ra[AW-1:0];
    bus.in_valid = v; bus.in_ip_addr_data = ip; bus.in_url_data = url;
    bus.in_last = last; start = st; bus.rd_address = a;
    #1;
    chk({tag, ".in_ready"}, 512'(bus.in_ready), 512'(m_cap));
    old = mem_m[ra]; oldv = wr_m[ra];
    @(posedge clk); #1;
    if (st) begin
      m_cap = 1; m_done = 0; m_count = 0; m_ovf = 0; m_drops = 0;
    end else if (m_cap && v) begin
      if (m_count < DEPTH) begin
        mem_m[m_count] = '{ip: ip, url: url};
        wr_m[m_count] = 1;
        m_count++;
      end else begin
        m_ovf = 1;
        if (m_drops < DMAX) m_drops++;
      end
      if (last) begin m_cap = 0; m_done = 1; end
    end
    if (oldv) begin
      chk({tag, ".rd_ip"}, 512'(bus.rd_ip_addr_data), 512'(old.ip));
      chk({tag, ".rd_url"}, bus.rd_url_data, old.url);
    end
    chk_status(tag);
    bus.in_valid = 0; bus.in_last = 0; start = 0;
  endtask

  task automatic run_random(input string tag, input int n);
    for (int k = 1; k <= n; k++)
      step(tag, 1, $urandom, rand_url(), k == n, 0, (m_count < DEPTH) ? m_count : 0);
  endtask

  task automatic read_all(input string tag, input int n);
    for (int a = 0; a < n; a++) step(tag, 0, '0, '0, 0, 0, a);
  endtask

  initial begin
    reset = 1; start = 0;
    bus.in_valid = 0; bus.in_last = 0; bus.in_ip_addr_data = '0;
    bus.in_url_data = '0; bus.rd_address = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst.in_ready", 512'(bus.in_ready), 512'(0));
    chk("rst.rd_ip", 512'(bus.rd_ip_addr_data), 512'(0));
    chk("rst.rd_url", bus.rd_url_data, 512'(0));
    chk_status("rst");
    reset = 0;

    // Idle beats without start are ignored; start with a beat present drops it.
    step("idle", 1, 32'hDEAD0001, rand_url(), 0, 0, 0);
    step("idle_start", 1, 32'hDEAD0002, rand_url(), 1, 1, 0);

    // Basic capture.
    for (int k = 1; k <= 3; k++)
      step("basic", 1, 32'h0A000000 + k, 512'(k), k == 3, 0, 0);
    step("basic_done", 1, 32'hBAD, '0, 0, 0, 0);
    read_all("basic_rd", 3);

    // Streaming with overflow: 10 beats into 8 slots, then saturation past 3 drops.
    step("strm_start", 0, '0, '0, 0, 1, 0);
    run_random("strm", 10);
    read_all("strm_rd", DEPTH);
    step("ovf_start", 0, '0, '0, 0, 1, 0);
    run_random("ovf", 13);
    step("ovf_after", 1, 32'h1, '0, 0, 0, 0);
    read_all("ovf_rd", DEPTH);

    // Restart after a 5-record run.
    step("rs_start", 0, '0, '0, 0, 1, 0);
    run_random("rs_a", 5);
    step("rs_restart", 0, '0, '0, 0, 1, 0);
    run_random("rs_b", 2);
    read_all("rs_rd", 5);

    // Start mid-capture with a beat in the same cycle.
    step("mid_start", 0, '0, '0, 0, 1, 0);
    run_random("mid_a", 2);
    for (int k = 0; k < 2; k++) step("mid_a2", 1, $urandom, rand_url(), 0, 0, k);
    step("mid_restart", 1, 32'hBEEF, rand_url(), 0, 1, 3);
    run_random("mid_b", 1);
    read_all("mid_rd", 2);

    // Async reset between edges after two beats.
    step("ar_start", 0, '0, '0, 0, 1, 0);
    for (int k = 0; k < 2; k++) step("ar_beat", 1, $urandom, rand_url(), 0, 0, k);
    #3 reset = 1;
    #1;
    m_cap = 0; m_done = 0; m_count = 0; m_ovf = 0; m_drops = 0;
    chk("ar.in_ready", 512'(bus.in_ready), 512'(0));
    chk("ar.rd_ip", 512'(bus.rd_ip_addr_data), 512'(0));
    chk("ar.rd_url", bus.rd_url_data, 512'(0));
    chk_status("ar");
    #2 reset = 0;
    for (int k = 0; k < 3; k++) step("ar_post", 1, $urandom, rand_url(), k == 2, 0, k);
    read_all("ar_rd", DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
